// File: rtl/srl_ctrl_pkg.sv
// Shared widths, default issue-word layout and the round-robin pick helper
// for the SRL issue controller.
package srl_ctrl_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 18;
    localparam int unsigned DEF_CREDITS    = 4;
    localparam int unsigned DEF_ID_WIDTH   = $clog2(DEF_NUM_REQ);
    localparam int unsigned DEF_CNT_WIDTH  = $clog2(DEF_CREDITS + 1);

    localparam int unsigned MAX_REQ    = 32;
    localparam int unsigned MAX_REQ_IW = $clog2(MAX_REQ);

    typedef struct packed {
        logic                      vld;
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_DATA_WIDTH-1:0] data;
    } iss_word_t;

    // One-hot pick of the first eligible index searching ptr, ptr+1, ... mod n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] elig,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int unsigned        idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n && !found) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (elig[idx[MAX_REQ_IW-1:0]]) begin
                    gnt[idx[MAX_REQ_IW-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the pointer register lives in the parent.
module rr_arbiter
    import srl_ctrl_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_gnt_o
);

    always_comb begin
        gnt_o     = N'(rr_pick(MAX_REQ'(elig_i), 32'(ptr_i), N));
        gnt_idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_o[i]) gnt_idx_o = IW'(i);
        end
        any_gnt_o = |gnt_o;
    end

endmodule

// File: rtl/srl_rr_issue_ctrl.sv
// Credit-based round-robin issue controller feeding a fixed-latency SRL datapath
// with a registered {vld, id, data} word.
module srl_rr_issue_ctrl
    import srl_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned CREDITS    = 4,
    localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ),
    localparam int unsigned CNT_WIDTH = $clog2(CREDITS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [NUM_REQ-1:0]              req_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_rdy,
    input  logic [NUM_REQ-1:0]              crd_ret,
    output logic                            iss_vld,
    output logic [ID_WIDTH-1:0]             iss_id,
    output logic [DATA_WIDTH-1:0]           iss_data,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    crd_cnt,
    output logic                            idle,
    output logic                            err_crd_ovf
);

    typedef struct packed {
        logic                  vld;
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
    } iss_q_t;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CREDITS);

    logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_REQ];
    logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    iss_q_t               iss_q, iss_d;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   gnt;
    logic [ID_WIDTH-1:0]  gnt_idx;
    logic                 any_gnt;
    logic [NUM_REQ-1:0]   ovf;

    // Eligibility uses only registered counts so req_rdy never sees crd_ret.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_vld[i] & (cnt_q[i] != '0) & enable;
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .elig_i    (elig),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    assign req_rdy = gnt;

    always_comb begin
        err_d = err_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf[i]   = 1'b0;
            case ({gnt[i], crd_ret[i]})
                2'b10: cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
                2'b01: begin
                    if (cnt_q[i] == CNT_FULL) ovf[i]   = 1'b1;
                    else                      cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        if (|ovf) err_d = 1'b1;
    end

    always_comb begin
        iss_d     = iss_q;
        iss_d.vld = any_gnt;
        rr_ptr_d  = rr_ptr_q;
        if (any_gnt) begin
            iss_d.id = gnt_idx;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) iss_d.data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            rr_ptr_d = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= CNT_FULL;
            rr_ptr_q <= '0;
            iss_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
            rr_ptr_q <= rr_ptr_d;
            iss_q    <= iss_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        idle = ~iss_q.vld;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            crd_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
            if (cnt_q[i] != CNT_FULL) idle = 1'b0;
        end
    end

    assign iss_vld     = iss_q.vld;
    assign iss_id      = iss_q.id;
    assign iss_data    = iss_q.data;
    assign err_crd_ovf = err_q;

endmodule

// File: tb/tb_srl_rr_issue_ctrl.sv
// Directed bench for srl_rr_issue_ctrl: grant vectors checked inline, issued
// words checked by a scoreboard monitor against hand-expected {id, data}.
module tb_srl_rr_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  req_vld;
    logic [71:0] req_data;
    logic [3:0]  req_rdy;
    logic [3:0]  crd_ret;
    logic        iss_vld;
    logic [1:0]  iss_id;
    logic [17:0] iss_data;
    logic [11:0] crd_cnt;
    logic        idle;
    logic        err_crd_ovf;

    typedef struct packed {
        logic [1:0]  id;
        logic [17:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [17:0] dat [4];

    srl_rr_issue_ctrl #(.NUM_REQ(4), .DATA_WIDTH(18), .CREDITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req_vld     (req_vld),
        .req_data    (req_data),
        .req_rdy     (req_rdy),
        .crd_ret     (crd_ret),
        .iss_vld     (iss_vld),
        .iss_id      (iss_id),
        .iss_data    (iss_data),
        .crd_cnt     (crd_cnt),
        .idle        (idle),
        .err_crd_ovf (err_crd_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every presented issue word must match the oldest expected grant.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && iss_vld) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got id %0d data %0h expected none", iss_id, iss_data);
            end else begin
                e = sb.pop_front();
                chk("iss_id", 32'(iss_id), 32'(e.id));
                chk("iss_data", 32'(iss_data), 32'(e.data));
            end
        end
    end

    function automatic logic [11:0] cnts(input int c3, input int c2, input int c1, input int c0);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    task automatic step(input logic [3:0] vld, input logic [3:0] ret, input logic en,
                        input logic [3:0] exp_rdy, input string nm);
        exp_t e;
        req_vld = vld;
        crd_ret = ret;
        enable  = en;
        @(negedge clk);
        chk(nm, 32'(req_rdy), 32'(exp_rdy));
        if (exp_rdy != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (exp_rdy[i]) begin
                    e.id   = 2'(i);
                    e.data = dat[i];
                end
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        crd_ret = 4'b0000;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dat[0] = 18'h0A5A5;
        dat[1] = 18'h15A5A;
        dat[2] = 18'h3FFFF;
        dat[3] = 18'h00001;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        rst = 1'b1; enable = 1'b0; req_vld = '0; crd_ret = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_idle", 32'(idle), 1);
        chk("rst_cnt", 32'(crd_cnt), 32'(cnts(4, 4, 4, 4)));
        chk("rst_iss_vld", 32'(iss_vld), 0);
        chk("rst_err", 32'(err_crd_ovf), 0);

        // 1) full contention drains every counter in 16 grants
        for (int k = 0; k < 16; k++) step(4'b1111, 4'b0000, 1'b1, 4'(1 << (k % 4)), "t1_rdy");
        step(4'b1111, 4'b0000, 1'b1, 4'b0000, "t1_rdy17");
        chk("t1_cnt0", 32'(crd_cnt), 0);
        chk("t1_iss_off", 32'(iss_vld), 0);
        for (int k = 0; k < 4; k++) step(4'b0000, 4'b1111, 1'b1, 4'b0000, "t1_ret");
        chk("t1_cnt_full", 32'(crd_cnt), 32'(cnts(4, 4, 4, 4)));
        chk("t1_idle", 32'(idle), 1);

        // 2) sparse requesters alternate
        for (int k = 0; k < 4; k++) step(4'b0101, 4'b0000, 1'b1, (k % 2 == 0) ? 4'b0001 : 4'b0100, "t2_rdy");
        chk("t2_cnt", 32'(crd_cnt), 32'(cnts(4, 2, 4, 2)));
        for (int k = 0; k < 2; k++) step(4'b0000, 4'b0101, 1'b1, 4'b0000, "t2_ret");

        // 3) a single returned credit buys exactly one grant, not on the return cycle
        for (int k = 0; k < 4; k++) step(4'b0001, 4'b0000, 1'b1, 4'b0001, "t3_drain");
        step(4'b0001, 4'b0000, 1'b1, 4'b0000, "t3_empty");
        step(4'b0001, 4'b0001, 1'b1, 4'b0000, "t3_ret_cycle");
        step(4'b0001, 4'b0000, 1'b1, 4'b0001, "t3_regrant");
        step(4'b0001, 4'b0000, 1'b1, 4'b0000, "t3_empty2");
        chk("t3_cnt", 32'(crd_cnt), 32'(cnts(4, 4, 4, 0)));
        for (int k = 0; k < 4; k++) step(4'b0000, 4'b0001, 1'b1, 4'b0000, "t3_ret");

        // 4) simultaneous grant+return keeps count; return to a full counter is sticky error
        step(4'b0100, 4'b0000, 1'b1, 4'b0100, "t4_g1");
        chk("t4_cnt3", 32'(crd_cnt), 32'(cnts(4, 3, 4, 4)));
        step(4'b0100, 4'b0100, 1'b1, 4'b0100, "t4_g_ret");
        chk("t4_cnt_hold", 32'(crd_cnt), 32'(cnts(4, 3, 4, 4)));
        chk("t4_no_err", 32'(err_crd_ovf), 0);
        step(4'b0000, 4'b0010, 1'b1, 4'b0000, "t4_ovf");
        chk("t4_err", 32'(err_crd_ovf), 1);
        chk("t4_cnt_sat", 32'(crd_cnt), 32'(cnts(4, 3, 4, 4)));
        step(4'b0000, 4'b0100, 1'b1, 4'b0000, "t4_ret2");
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, "t4_idle");
        chk("t4_err_sticky", 32'(err_crd_ovf), 1);

        // 5) enable low holds off grants; resume from held pointer (3)
        step(4'b1111, 4'b0000, 1'b0, 4'b0000, "t5_dis1");
        step(4'b1111, 4'b0000, 1'b0, 4'b0000, "t5_dis2");
        chk("t5_iss_off", 32'(iss_vld), 0);
        step(4'b1111, 4'b0000, 1'b1, 4'b1000, "t5_resume");
        step(4'b1111, 4'b0000, 1'b1, 4'b0001, "t5_next");

        // 6) async reset mid-burst
        step(4'b1111, 4'b0000, 1'b1, 4'b0010, "t6_pre");
        chk("t6_pre_rdy", 32'(req_rdy), 32'(4'b0100));
        #2 rst = 1'b1;
        sb.delete();
        #1;
        chk("t6_iss_vld", 32'(iss_vld), 0);
        chk("t6_cnt", 32'(crd_cnt), 32'(cnts(4, 4, 4, 4)));
        chk("t6_idle", 32'(idle), 1);
        chk("t6_ptr", 32'(req_rdy), 32'(4'b0001));
        chk("t6_err_clr", 32'(err_crd_ovf), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(4'b1111, 4'b0000, 1'b1, 4'b0001, "t6_post");
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, "t6_quiet");
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, "t6_quiet2");
        chk("sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
